hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). It
//  decodes the ID-stage instruction word (the same word the immediate
//  generator consumes) and tracks a shadow record of instructions in EX/MEM/WB.
//  From that state it drives PC/IF-ID enables, IF-ID and ID-EX flushes, and EX
//  operand forwarding selects. It also keeps saturating stall and flush counters.
// PARAMETERS
//  CNT_W   16   width of o_stall_cnt / o_flush_cnt (saturating)
// PORTS
//  i_clk          in   1      core clock; single clock domain
//  i_rst_n        in   1      reset, synchronous, active-low
//  i_id_inst      in   32     instruction word currently in IF/ID
//  i_id_valid     in   1      IF/ID holds a real instruction
//  i_ex_redirect  in   1      EX resolved taken branch/jal/jalr; held while stalled
//  i_dmem_stall   in   1      data memory not ready; freeze whole pipe
//  o_pc_en        out  1      PC register load enable
//  o_ifid_en      out  1      IF/ID register load enable
//  o_ifid_flush   out  1      IF/ID <- NOP
//  o_idex_flush   out  1      ID/EX <- bubble
//  o_fwd_a        out  2      EX rs1 source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  o_fwd_b        out  2      EX rs2 source, same encoding
//  o_stall_cnt    out  CNT_W  load-use stall cycles since reset
//  o_flush_cnt    out  CNT_W  redirect flush events since reset
// BEHAVIOUR
//  - Decode from opcode i_id_inst[6:0]:
//    uses_rs1: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, jalr 1100111.
//    uses_rs2: R, store, branch.
//    writes_rd: R, I, load, lui 0110111, auipc 0010111, jal 1101111, jalr; rd==0 -> no write.
//    Other opcodes: no use, no write. Gate all of this with i_id_valid.
//  - Shadow state: ex{v,rd,rs1,rs2,load}, mem{v,rd,load}, wb{v,rd}.
//    When i_dmem_stall=0 it advances: wb<-mem, mem<-ex, ex<-decoded ID.
//    ex.v is forced to 0 on a bubble or flush.
//  - Priority each cycle, evaluated combinationally on current state and inputs:
//    1 i_dmem_stall=1: pc_en=ifid_en=0, both flushes=0, no shadow advance, no counter change.
//    2 i_ex_redirect=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1; flush_cnt+1.
//      Redirect overrides a coincident load-use condition.
//    3 load-use: ex.v & ex.load & ex.rd!=0 & ((uses_rs1 & rs1==ex.rd) | (uses_rs2 & rs2==ex.rd)).
//      Action: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; stall_cnt+1. Lasts exactly one
//      cycle, because next cycle the load is in MEM and the consumer gets MEM/WB forwarding.
//    4 else: pc_en=ifid_en=1, flushes=0.
//  - Forwarding for the EX instruction, rs1 and rs2 independently; x0 never forwarded:
//    01 if mem.v & !mem.load & mem.rd==ex.rs; else 10 if wb.v & wb.rd==ex.rs; else 00.
//    MEM beats WB when both match. fwd outputs are meaningful only while ex.v=1; 00 when ex.v=0.
//  - Counters saturate at all-ones and never wrap.
//  - Reset (i_rst_n=0 at a clock edge):
//    clears all shadow valids and both counters.
//    While reset is low: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, fwd=00.
//    Reset mid-stall or mid-redirect discards the event.
//  - Latency: control outputs are same-cycle combinational; state updates on the clock edge.
// STRUCTURE
//  - riscv_pkg: opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL,
//    OP_JALR, OP_LUI, OP_AUIPC) and enum fwd_sel_e {FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2}.
//  - Sub-module hazard_decode (combinational): i_inst -> rs1, rs2, rd, uses_rs1,
//    uses_rs2, writes_rd, is_load. hazard_ctrl holds all sequential state.
// TESTING
//  1 lw x5,0(x1) 0x0000A283 then add x6,x5,x2 0x00228333
//    -> one cycle pc_en=0, idex_flush=1, stall_cnt=1; next cycle fwd_a=10, fwd_b=00.
//  2 add x5,.. then add x6,x5,x5 back-to-back -> no stall; fwd_a=fwd_b=01.
//    With one unrelated instruction between them -> fwd=10.
//  3 i_ex_redirect=1 coincident with a load-use condition
//    -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
//  4 i_dmem_stall=1 for 3 cycles during a redirect -> outputs frozen, counters unchanged.
//    On release: one flush, flush_cnt+1.
//  5 rd=x0 producer (addi x0,x0,1) then a consumer of x0 -> fwd=00, no stall.
//    lui consumer (no rs use) after a load of x5 -> no stall.
//  6 Force stall_cnt to all-ones and trigger a load-use -> holds 0xFFFF.
//    Assert i_rst_n=0 mid-stall -> counters 0, flushes=1; first post-reset cycle normal.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared opcode constants, forwarding-select encoding and
//                shadow-pipeline record types for the hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Register fields hold 0 when the instruction does not use/write them,
  // so "x0 never matches" also covers unused operands.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       load;
  } ex_rec_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       load;
  } mem_rec_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } wb_rec_t;

  // A load in MEM has no data yet, so only a non-load MEM result may be
  // forwarded; a younger MEM result beats an older WB result.
  function automatic fwd_sel_e fwd_pick(input logic [4:0] rs,
                                        input mem_rec_t   m,
                                        input wb_rec_t    w);
    fwd_pick = FWD_RF;
    if (rs != 5'd0) begin
      if (m.v && !m.load && (m.rd == rs)) begin
        fwd_pick = FWD_EXMEM;
      end else if (w.v && (w.rd == rs)) begin
        fwd_pick = FWD_MEMWB;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller.
//                master (datapath) drives : i_id_inst, i_id_valid,
//                                           i_ex_redirect, i_dmem_stall
//                slave  (controller) drives: o_pc_en, o_ifid_en,
//                                           o_ifid_flush, o_idex_flush,
//                                           o_fwd_a, o_fwd_b,
//                                           o_stall_cnt, o_flush_cnt
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      i_id_inst;
  logic             i_id_valid;
  logic             i_ex_redirect;
  logic             i_dmem_stall;
  logic             o_pc_en;
  logic             o_ifid_en;
  logic             o_ifid_flush;
  logic             o_idex_flush;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_id_inst, i_id_valid, i_ex_redirect, i_dmem_stall,
    input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush,
           o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_inst, i_id_valid, i_ex_redirect, i_dmem_stall,
    output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush,
           o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_decode
//  Description : Combinational register-usage decode of the ID instruction.
//                i_inst, i_valid  -> o_rs1, o_rs2, o_rd, o_uses_rs1,
//                o_uses_rs2, o_writes_rd, o_is_load (flags gated by i_valid)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_decode
  import riscv_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic        i_valid,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_writes_rd,
  output logic        o_is_load
);

  logic       use1;
  logic       use2;
  logic       wr;
  logic       ld;
  logic       unused_bits;

  assign o_rs1       = i_inst[19:15];
  assign o_rs2       = i_inst[24:20];
  assign o_rd        = i_inst[11:7];
  assign unused_bits = ^{i_inst[31:25], i_inst[14:12]};

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    wr   = 1'b0;
    ld   = 1'b0;
    case (i_inst[6:0])
      OP_R:     begin use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
      OP_I:     begin use1 = 1'b1; wr = 1'b1; end
      OP_LOAD:  begin use1 = 1'b1; wr = 1'b1; ld = 1'b1; end
      OP_STORE: begin use1 = 1'b1; use2 = 1'b1; end
      OP_BR:    begin use1 = 1'b1; use2 = 1'b1; end
      OP_JALR:  begin use1 = 1'b1; wr = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: wr = 1'b1;
      default:  ;
    endcase
  end

  assign o_uses_rs1  = i_valid & use1;
  assign o_uses_rs2  = i_valid & use2;
  assign o_writes_rd = i_valid & wr & (i_inst[11:7] != 5'd0);
  assign o_is_load   = i_valid & ld;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : 5-stage pipeline sequencing controller. Tracks a shadow
//                record of EX/MEM/WB, detects load-use hazards, applies
//                redirect flushes and memory freezes, selects EX operand
//                forwarding and keeps saturating stall/flush counters.
//                Ports: i_clk, i_rst_n (sync, active-low),
//                       bus (hazard_ctrl_if.slave) carrying the pipeline
//                       inputs and all control/counter outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  hazard_ctrl_if.slave bus
);

  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       d_uses_rs1, d_uses_rs2, d_writes_rd, d_is_load;

  ex_rec_t    ex_q,  ex_d;
  mem_rec_t   mem_q, mem_d;
  wb_rec_t    wb_q,  wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       load_use;
  logic       pc_en, ifid_en, ifid_flush, idex_flush;
  logic       stall_inc, flush_inc;
  fwd_sel_e   fwd_a, fwd_b;

  hazard_decode u_decode (
    .i_inst      (bus.i_id_inst),
    .i_valid     (bus.i_id_valid),
    .o_rs1       (d_rs1),
    .o_rs2       (d_rs2),
    .o_rd        (d_rd),
    .o_uses_rs1  (d_uses_rs1),
    .o_uses_rs2  (d_uses_rs2),
    .o_writes_rd (d_writes_rd),
    .o_is_load   (d_is_load)
  );

  always_comb begin
    load_use = ex_q.v && ex_q.load && (ex_q.rd != 5'd0) &&
               ((d_uses_rs1 && (d_rs1 == ex_q.rd)) ||
                (d_uses_rs2 && (d_rs2 == ex_q.rd)));

    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (!i_rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (bus.i_dmem_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (bus.i_ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (load_use) begin
      // One bubble suffices: next cycle the load sits in MEM and the
      // consumer picks it up through MEM/WB forwarding one cycle later.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
    end
  end

  always_comb begin
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.i_dmem_stall) begin
      wb_d.v     = mem_q.v;
      wb_d.rd    = mem_q.rd;
      mem_d.v    = ex_q.v;
      mem_d.rd   = ex_q.rd;
      mem_d.load = ex_q.load;
      ex_d.v     = bus.i_id_valid && !idex_flush;
      ex_d.rd    = d_writes_rd ? d_rd  : 5'd0;
      ex_d.rs1   = d_uses_rs1  ? d_rs1 : 5'd0;
      ex_d.rs2   = d_uses_rs2  ? d_rs2 : 5'd0;
      ex_d.load  = d_is_load;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (i_rst_n && ex_q.v) begin
      fwd_a = fwd_pick(ex_q.rs1, mem_q, wb_q);
      fwd_b = fwd_pick(ex_q.rs2, mem_q, wb_q);
    end
  end

  assign bus.o_pc_en      = pc_en;
  assign bus.o_ifid_en    = ifid_en;
  assign bus.o_ifid_flush = ifid_flush;
  assign bus.o_idex_flush = idex_flush;
  assign bus.o_fwd_a      = fwd_a;
  assign bus.o_fwd_b      = fwd_b;
  assign bus.o_stall_cnt  = stall_cnt_q;
  assign bus.o_flush_cnt  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Each cycle drives the
//                ID instruction and control inputs, queues the expected
//                outputs and compares them mid-cycle. Counters use a 4-bit
//                width so saturation is reachable quickly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [31:0] NOP     = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] LW5     = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD6_52 = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] ADD5_12 = 32'h0020_82B3; // add  x5,x1,x2
  localparam logic [31:0] ADD6_55 = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] ADDI9   = 32'h0000_0493; // addi x9,x0,0
  localparam logic [31:0] ADDI0_1 = 32'h0010_0013; // addi x0,x0,1
  localparam logic [31:0] ADD7_00 = 32'h0000_03B3; // add  x7,x0,x0
  localparam logic [31:0] LUI7    = 32'h0000_13B7; // lui  x7,1

  typedef struct {
    logic             pc;
    logic             ifl;
    logic             idl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    int               cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_sc = '0;
  logic [CNT_W-1:0] exp_fc = '0;
  int               cyc    = 0;
  int               n_checks = 0;
  int               n_errors = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, then
  // advance the counter expectation for the coming clock edge.
  task automatic step(input logic rstn, input logic [31:0] inst, input logic vld,
                      input logic redir, input logic dst,
                      input logic e_pc, input logic e_ifl, input logic e_idl,
                      input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    exp_t g;
    rst_n             = rstn;
    hif.i_id_inst     = inst;
    hif.i_id_valid    = vld;
    hif.i_ex_redirect = redir;
    hif.i_dmem_stall  = dst;
    e.pc = e_pc; e.ifl = e_ifl; e.idl = e_idl; e.fa = e_fa; e.fb = e_fb;
    e.sc = exp_sc; e.fc = exp_fc; e.cyc = cyc;
    sb.push_back(e);

    @(negedge clk);
    g = sb.pop_front();
    check_eq($sformatf("c%0d.pc_en",      g.cyc), 32'(hif.o_pc_en),      32'(g.pc));
    check_eq($sformatf("c%0d.ifid_en",    g.cyc), 32'(hif.o_ifid_en),    32'(g.pc));
    check_eq($sformatf("c%0d.ifid_flush", g.cyc), 32'(hif.o_ifid_flush), 32'(g.ifl));
    check_eq($sformatf("c%0d.idex_flush", g.cyc), 32'(hif.o_idex_flush), 32'(g.idl));
    check_eq($sformatf("c%0d.fwd_a",      g.cyc), 32'(hif.o_fwd_a),      32'(g.fa));
    check_eq($sformatf("c%0d.fwd_b",      g.cyc), 32'(hif.o_fwd_b),      32'(g.fb));
    check_eq($sformatf("c%0d.stall_cnt",  g.cyc), 32'(hif.o_stall_cnt),  32'(g.sc));
    check_eq($sformatf("c%0d.flush_cnt",  g.cyc), 32'(hif.o_flush_cnt),  32'(g.fc));

    if (!rstn) begin
      exp_sc = '0;
      exp_fc = '0;
    end else if (!dst) begin
      if (e_ifl) begin
        if (exp_fc != {CNT_W{1'b1}}) exp_fc = exp_fc + 1'b1;
      end else if (e_idl) begin
        if (exp_sc != {CNT_W{1'b1}}) exp_sc = exp_sc + 1'b1;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    hif.i_id_inst     = NOP;
    hif.i_id_valid    = 1'b0;
    hif.i_ex_redirect = 1'b0;
    hif.i_dmem_stall  = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    step(0, NOP, 0, 0, 0,  0, 1, 1, 2'd0, 2'd0);
    step(0, NOP, 0, 0, 0,  0, 1, 1, 2'd0, 2'd0);

    // load-use: one bubble, then MEM/WB forwarding on rs1
    step(1, LW5,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, ADD6_52, 1, 0, 0,  0, 0, 1, 2'd0, 2'd0);
    step(1, ADD6_52, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd2, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);

    // back-to-back ALU dependency -> EX/MEM on both operands
    step(1, ADD5_12, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, ADD6_55, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd1, 2'd1);

    // one unrelated instruction between -> MEM/WB on both operands
    step(1, ADD5_12, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, ADDI9,   1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, ADD6_55, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd2, 2'd2);

    // redirect overrides a coincident load-use
    step(1, LW5,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, ADD6_52, 1, 1, 0,  1, 1, 1, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);

    // memory freeze during a redirect, then the redirect lands once
    for (int i = 0; i < 3; i++) begin
      step(1, NOP,   1, 1, 1,  0, 0, 0, 2'd0, 2'd0);
    end
    step(1, NOP,     1, 1, 0,  1, 1, 1, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);

    // x0 producer/consumer never forwards; lui after a load never stalls
    step(1, ADDI0_1, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, ADD7_00, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, LW5,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, LUI7,    1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);

    // repeated load-use drives stall_cnt into saturation
    for (int i = 0; i < 15; i++) begin
      step(1, LW5,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
      step(1, ADD6_52, 1, 0, 0,  0, 0, 1, 2'd0, 2'd0);
      step(1, ADD6_52, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
      step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd2, 2'd0);
    end
    check_eq("stall_cnt_sat", 32'(hif.o_stall_cnt), 32'hF);

    // reset while a load-use is pending discards it
    step(1, LW5,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(0, ADD6_52, 1, 0, 0,  0, 1, 1, 2'd0, 2'd0);
    step(1, ADD6_52, 1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);
    step(1, NOP,     1, 0, 0,  1, 0, 0, 2'd0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
